// File: rtl/rw_cmd_arbiter.sv
// Read/write command arbiter for the single DDR command slot: batches same-direction
// commands up to a burst limit and inserts a fixed idle gap on each direction switch.
module rw_cmd_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ID_W-1:0]   rd_id,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ID_W-1:0]   wr_id,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [ID_W-1:0]   cmd_id,
    output logic              busy_turn
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int TCW = $clog2(TURN_CYCLES + 1);
    localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST);
    localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYCLES);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } cmd_t;

    cmd_t           cmd_q, cmd_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           last_dir_q, last_dir_d;     // 0 = read, 1 = write
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [TCW-1:0] turn_cnt_q, turn_cnt_d;

    logic slot_free;
    logic arb_en;
    logic any_req;
    logic cand;
    logic grant;
    logic do_switch;

    // cmd_ready feeds straight through to the requester readies so a drain and a
    // new grant can share one cycle without a bubble.
    assign slot_free = !cmd_valid_q || cmd_ready;
    assign arb_en    = slot_free && (turn_cnt_q == '0);
    assign any_req   = rd_valid || wr_valid;

    always_comb begin
        cand = last_dir_q;
        if (rd_valid && wr_valid)
            cand = (burst_cnt_q >= BURST_LIM) ? ~last_dir_q : last_dir_q;
        else if (wr_valid)
            cand = 1'b1;
        else if (rd_valid)
            cand = 1'b0;
    end

    assign grant     = arb_en && any_req && (cand == last_dir_q);
    assign do_switch = arb_en && any_req && (cand != last_dir_q);

    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        last_dir_d  = last_dir_q;
        burst_cnt_d = burst_cnt_q;
        turn_cnt_d  = turn_cnt_q;

        if (grant) begin
            cmd_valid_d = 1'b1;
            cmd_d.write = cand;
            cmd_d.addr  = cand ? wr_addr : rd_addr;
            cmd_d.id    = cand ? wr_id : rd_id;
            if (burst_cnt_q < BURST_LIM)
                burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        // The gap counter runs regardless of output drain; the sequencer owns
        // any further bus timing.
        if (do_switch) begin
            last_dir_d  = cand;
            burst_cnt_d = '0;
            turn_cnt_d  = TURN_LOAD;
        end else if (turn_cnt_q != '0) begin
            turn_cnt_d = turn_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            last_dir_q  <= 1'b0;
            burst_cnt_q <= '0;
            turn_cnt_q  <= '0;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            last_dir_q  <= last_dir_d;
            burst_cnt_q <= burst_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    assign rd_ready  = grant && !cand;
    assign wr_ready  = grant && cand;
    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_q.write;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_id    = cmd_q.id;
    assign busy_turn = (turn_cnt_q != '0);

endmodule

// File: tb/tb_rw_cmd_arbiter.sv
// Directed bench for rw_cmd_arbiter: batching, turnaround gap, back-pressure,
// starvation avoidance and reset in the middle of traffic.
module tb_rw_cmd_arbiter;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              rd_valid, rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [ID_W-1:0]   rd_id;
    logic              wr_valid, wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [ID_W-1:0]   wr_id;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ID_W-1:0]   cmd_id;
    logic              busy_turn;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    rw_cmd_arbiter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BURST(8), .TURN_CYCLES(2)) dut (
        .clk(clk), .n_rst(n_rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_id(rd_id),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_id(wr_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_id(cmd_id), .busy_turn(busy_turn)
    );

    always #5 clk = ~clk;

    // inputs change 1 time unit after the rising edge; outputs are read 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        rd_valid = 1'b0; rd_addr = '0; rd_id = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_id = '0;
        cmd_ready = 1'b1;
        step();
        step();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tot_cnt++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_id, busy_turn, rd_ready, wr_ready} !== '0)
            $display("FAIL reset_state got v=%b w=%b a=%h id=%h bt=%b rr=%b wr=%b exp all 0",
                     cmd_valid, cmd_write, cmd_addr, cmd_id, busy_turn, rd_ready, wr_ready);
        else pass_cnt++;
    endtask

    task automatic test_reads();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            rd_valid = 1'b1; rd_id = ID_W'(i); rd_addr = 32'h100 + i;
            #1;
            tot_cnt++;
            if ({rd_ready, wr_ready, busy_turn} !== 3'b100)
                $display("FAIL reads_ready%0d got rr/wr/bt=%b%b%b exp 100", i, rd_ready, wr_ready, busy_turn);
            else pass_cnt++;
            step();
            tot_cnt++;
            if ({cmd_valid, cmd_write, cmd_id, cmd_addr} !== {1'b1, 1'b0, ID_W'(i), 32'h100 + i})
                $display("FAIL reads_cmd%0d got v=%b w=%b id=%0d a=%h exp v=1 w=0 id=%0d a=%h",
                         i, cmd_valid, cmd_write, cmd_id, cmd_addr, i, 32'h100 + i);
            else pass_cnt++;
        end
        rd_valid = 1'b0;
        step();
        tot_cnt++;
        if ({cmd_valid, busy_turn} !== 2'b00)
            $display("FAIL reads_drain got v=%b bt=%b exp 0 0", cmd_valid, busy_turn);
        else pass_cnt++;
    endtask

    task automatic test_write_turn();
        logic [2:0] exp_rwb [0:3];
        exp_rwb[0] = 3'b000; exp_rwb[1] = 3'b001; exp_rwb[2] = 3'b001; exp_rwb[3] = 3'b010;
        do_reset();
        wr_valid = 1'b1; wr_id = 4'd5; wr_addr = 32'hA5A5_0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            tot_cnt++;
            if ({rd_ready, wr_ready, busy_turn} !== exp_rwb[c])
                $display("FAIL write_turn_c%0d got rr/wr/bt=%b%b%b exp %b", c, rd_ready, wr_ready, busy_turn, exp_rwb[c]);
            else pass_cnt++;
            step();
        end
        wr_valid = 1'b0;
        tot_cnt++;
        if ({cmd_valid, cmd_write, cmd_id, cmd_addr} !== {1'b1, 1'b1, 4'd5, 32'hA5A5_0000})
            $display("FAIL write_turn_cmd got v=%b w=%b id=%0d a=%h exp v=1 w=1 id=5 a=a5a50000",
                     cmd_valid, cmd_write, cmd_id, cmd_addr);
        else pass_cnt++;
    endtask

    task automatic test_both();
        logic [2:0] exp_rwb;
        int p;
        do_reset();
        rd_valid = 1'b1; wr_valid = 1'b1; rd_id = 4'd1; wr_id = 4'd2;
        // 8 reads, switch + 2 idle, 8 writes, switch + 2 idle: period 22
        for (int c = 0; c < 44; c++) begin
            p = c % 22;
            exp_rwb = 3'b000;
            if (p < 8) exp_rwb = 3'b100;
            else if (p >= 11 && p < 19) exp_rwb = 3'b010;
            else if (p == 9 || p == 10 || p == 20 || p == 21) exp_rwb = 3'b001;
            #1;
            tot_cnt++;
            if ({rd_ready, wr_ready, busy_turn} !== exp_rwb)
                $display("FAIL both_c%0d got rr/wr/bt=%b%b%b exp %b", c, rd_ready, wr_ready, busy_turn, exp_rwb);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rd_valid = 1'b1; rd_id = 4'd7; rd_addr = 32'h0000_7777;
        step();
        cmd_ready = 1'b0; rd_id = 4'd8; rd_addr = 32'h0000_8888;
        for (int k = 0; k < 5; k++) begin
            #1;
            tot_cnt++;
            if ({rd_ready, cmd_valid, cmd_id, cmd_addr} !== {1'b0, 1'b1, 4'd7, 32'h0000_7777})
                $display("FAIL stall_c%0d got rr=%b v=%b id=%0d a=%h exp rr=0 v=1 id=7 a=00007777",
                         k, rd_ready, cmd_valid, cmd_id, cmd_addr);
            else pass_cnt++;
            step();
        end
        cmd_ready = 1'b1;
        #1;
        tot_cnt++;
        if (rd_ready !== 1'b1) $display("FAIL stall_release got rr=%b exp 1", rd_ready);
        else pass_cnt++;
        step();
        rd_valid = 1'b0;
        tot_cnt++;
        if ({cmd_valid, cmd_id, cmd_addr} !== {1'b1, 4'd8, 32'h0000_8888})
            $display("FAIL stall_next got v=%b id=%0d a=%h exp v=1 id=8 a=00008888", cmd_valid, cmd_id, cmd_addr);
        else pass_cnt++;
    endtask

    task automatic test_no_starve();
        int n;
        do_reset();
        rd_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rd_valid = 1'b0; wr_valid = 1'b1; wr_id = 4'd9; wr_addr = 32'h9000;
        #1;
        tot_cnt++;
        if ({rd_ready, wr_ready, busy_turn} !== 3'b000)
            $display("FAIL starve_switch got rr/wr/bt=%b%b%b exp 000", rd_ready, wr_ready, busy_turn);
        else pass_cnt++;
        step(); step(); step();
        #1;
        tot_cnt++;
        if ({wr_ready, busy_turn} !== 2'b10)
            $display("FAIL starve_grant got wr/bt=%b%b exp 10", wr_ready, busy_turn);
        else pass_cnt++;
        step();
        tot_cnt++;
        if ({cmd_valid, cmd_write, cmd_id} !== {1'b1, 1'b1, 4'd9})
            $display("FAIL starve_cmd got v=%b w=%b id=%0d exp v=1 w=1 id=9", cmd_valid, cmd_write, cmd_id);
        else pass_cnt++;
        // burst counter restarted at the switch, so a full burst of 8 writes follows
        rd_valid = 1'b1;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!wr_ready) break;
            n++;
            step();
        end
        tot_cnt++;
        if (n !== 8) $display("FAIL starve_burst got %0d writes exp 8", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_valid = 1'b1; rd_id = 4'd3; rd_addr = 32'h33;
        step();
        rd_valid = 1'b0; cmd_ready = 1'b0;
        step();
        n_rst = 1'b0;
        #1;
        tot_cnt++;
        if ({cmd_valid, cmd_id, cmd_addr} !== '0)
            $display("FAIL rst_held got v=%b id=%0d a=%h exp all 0", cmd_valid, cmd_id, cmd_addr);
        else pass_cnt++;
        step();
        n_rst = 1'b1; cmd_ready = 1'b1;
        wr_valid = 1'b1; wr_id = 4'd4;
        #1;
        tot_cnt++;
        if (wr_ready !== 1'b0) $display("FAIL rst_first_write got wr=%b exp 0", wr_ready);
        else pass_cnt++;
        step(); step();
        tot_cnt++;
        if (busy_turn !== 1'b1) $display("FAIL rst_turn1 got bt=%b exp 1", busy_turn);
        else pass_cnt++;
        n_rst = 1'b0;
        #1;
        tot_cnt++;
        if ({cmd_valid, busy_turn, rd_ready, wr_ready} !== 4'b0000)
            $display("FAIL rst_mid_turn got v/bt/rr/wr=%b%b%b%b exp 0000", cmd_valid, busy_turn, rd_ready, wr_ready);
        else pass_cnt++;
        step();
        n_rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b1; rd_id = 4'd6;
        #1;
        tot_cnt++;
        if ({rd_ready, busy_turn} !== 2'b10)
            $display("FAIL rst_first_read got rr/bt=%b%b exp 10", rd_ready, busy_turn);
        else pass_cnt++;
        step();
        rd_valid = 1'b0;
        tot_cnt++;
        if ({cmd_valid, cmd_write, cmd_id} !== {1'b1, 1'b0, 4'd6})
            $display("FAIL rst_read_cmd got v=%b w=%b id=%0d exp v=1 w=0 id=6", cmd_valid, cmd_write, cmd_id);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reads();
        test_write_turn();
        test_both();
        test_back_to_back();
        test_no_starve();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
